// File: rtl/timer_pkg.sv
// Shared definitions for the timer: register indices, TAC fields, tap codes, FSM states.
package timer_pkg;

   // Register window indices (addr port)
   localparam logic [1:0] REG_NONE = 2'd0;
   localparam logic [1:0] REG_TIMA = 2'd1;
   localparam logic [1:0] REG_TMA  = 2'd2;
   localparam logic [1:0] REG_TAC  = 2'd3;

   // TAC field positions
   localparam int TAC_EN_BIT  = 2;
   localparam int TAC_SEL_MSB = 1;
   localparam int TAC_SEL_LSB = 0;

   // Tap select encoding into div_tap
   localparam logic [1:0] TAP_4096   = 2'd0;
   localparam logic [1:0] TAP_262144 = 2'd1;
   localparam logic [1:0] TAP_65536  = 2'd2;
   localparam logic [1:0] TAP_16384  = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_OVF    = 2'd1,
      ST_RELOAD = 2'd2
   } state_t;

   // TAC reads back with the unimplemented upper bits as ones
   function automatic logic [7:0] tac_readback(input logic [2:0] tac);
      return {5'b11111, tac};
   endfunction

endpackage

// File: rtl/timer_if.sv
// CPU register-window bus between the address decoder and the timer.
interface timer_if;
   logic       sel;
   logic [1:0] addr;
   logic       wr;
   logic       rd;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dout_en;

   modport master (output sel, output addr, output wr, output rd, output din,
                   input dout, input dout_en);
   modport slave  (input sel, input addr, input wr, input rd, input din,
                   output dout, output dout_en);
endinterface

// File: rtl/timer_edge.sv
// Tick source selection and falling-edge detector. Because the enable bit is
// ANDed in before the edge detector, clearing TAC or a divider reset can
// produce a spurious increment, matching the original hardware.
module timer_edge
   import timer_pkg::*;
(
   input  logic       clk,
   input  logic       nreset,
   input  logic [2:0] tac,
   input  logic [3:0] div_tap,
   output logic       tick_fall
);

   logic tick_src_s;
   logic tick_prev_r;

   // Gate the selected divider tap with the timer enable
   always_comb begin
      tick_src_s = 1'b0;
      if (tac[TAC_EN_BIT]) begin
         tick_src_s = div_tap[tac[TAC_SEL_MSB:TAC_SEL_LSB]];
      end else begin
         tick_src_s = 1'b0;
      end
   end

   // Remember last cycle's tick source for edge detection
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tick_prev_r <= 1'b0;
      end else begin
         tick_prev_r <= tick_src_s;
      end
   end

   assign tick_fall = tick_prev_r & ~tick_src_s;

endmodule

// File: rtl/timer.sv
// DMG-style programmable timer: TIMA counter, TMA modulo, TAC control,
// delayed reload after overflow and a one-cycle interrupt pulse.
module timer
   import timer_pkg::*;
#(
   parameter logic [7:0] TIMA_INIT = 8'h00
)
(
   input  logic       clk,
   input  logic       nreset,
   input  logic [3:0] div_tap,
   timer_if.slave     bus,
   output logic       timer_irq
);

   logic [7:0] tima_r;
   logic [7:0] tma_r;
   logic [2:0] tac_r;
   state_t     state_r;
   logic       irq_r;

   logic [7:0] tima_nxt_s;
   logic [7:0] tma_nxt_s;
   logic [2:0] tac_nxt_s;
   state_t     state_nxt_s;

   logic       tick_fall_s;
   logic       wr_s;
   logic       wr_tima_s;
   logic       wr_tma_s;
   logic       wr_tac_s;
   logic       dout_en_s;
   logic [7:0] dout_s;

   timer_edge u_edge (
      .clk       (clk),
      .nreset    (nreset),
      .tac       (tac_r),
      .div_tap   (div_tap),
      .tick_fall (tick_fall_s)
   );

   // Decode CPU write strobes per register
   always_comb begin
      wr_s      = bus.sel & bus.wr;
      wr_tima_s = wr_s & (bus.addr == REG_TIMA);
      wr_tma_s  = wr_s & (bus.addr == REG_TMA);
      wr_tac_s  = wr_s & (bus.addr == REG_TAC);
   end

   // Next-state logic for the overflow/reload FSM and TIMA
   always_comb begin
      tima_nxt_s  = tima_r;
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (wr_tima_s) begin
               // CPU write beats a same-cycle increment
               tima_nxt_s = bus.din;
            end else if (tick_fall_s) begin
               if (tima_r == 8'hFF) begin
                  tima_nxt_s  = 8'h00;
                  state_nxt_s = ST_OVF;
               end else begin
                  tima_nxt_s = tima_r + 8'd1;
               end
            end else begin
               tima_nxt_s = tima_r;
            end
         end
         ST_OVF: begin
            if (wr_tima_s) begin
               // Writing TIMA here cancels the pending reload and interrupt
               tima_nxt_s  = bus.din;
               state_nxt_s = ST_RUN;
            end else begin
               // Any tick in this cycle is lost under the reload
               tima_nxt_s  = tma_r;
               state_nxt_s = ST_RELOAD;
            end
         end
         ST_RELOAD: begin
            // TIMA writes are dropped; a TMA write passes through to TIMA
            if (wr_tma_s) begin
               tima_nxt_s = bus.din;
            end else begin
               tima_nxt_s = tima_r;
            end
            state_nxt_s = ST_RUN;
         end
         default: begin
            tima_nxt_s  = tima_r;
            state_nxt_s = ST_RUN;
         end
      endcase
   end

   // Next values for TMA and TAC
   always_comb begin
      tma_nxt_s = tma_r;
      tac_nxt_s = tac_r;
      if (wr_tma_s) begin
         tma_nxt_s = bus.din;
      end else begin
         tma_nxt_s = tma_r;
      end
      if (wr_tac_s) begin
         tac_nxt_s = bus.din[2:0];
      end else begin
         tac_nxt_s = tac_r;
      end
   end

   // State, register file and registered interrupt output
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tima_r  <= TIMA_INIT;
         tma_r   <= 8'h00;
         tac_r   <= 3'b000;
         state_r <= ST_RUN;
         irq_r   <= 1'b0;
      end else begin
         tima_r  <= tima_nxt_s;
         tma_r   <= tma_nxt_s;
         tac_r   <= tac_nxt_s;
         state_r <= state_nxt_s;
         irq_r   <= (state_nxt_s == ST_RELOAD);
      end
   end

   // Combinational read mux for the shared data bus
   always_comb begin
      dout_en_s = bus.sel & bus.rd & (bus.addr != REG_NONE);
      dout_s    = 8'hFF;
      if (dout_en_s) begin
         case (bus.addr)
            REG_TIMA: dout_s = tima_r;
            REG_TMA:  dout_s = tma_r;
            REG_TAC:  dout_s = tac_readback(tac_r);
            default:  dout_s = 8'hFF;
         endcase
      end else begin
         dout_s = 8'hFF;
      end
   end

   assign bus.dout    = dout_s;
   assign bus.dout_en = dout_en_s;
   assign timer_irq   = irq_r;

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for the timer.
module tb_timer;

   logic       clk;
   logic       nreset;
   logic [3:0] div_tap;
   logic       timer_irq;
   int         n_pass;
   int         n_fail;
   int         n_total;

   timer_if tbus ();

   timer #(.TIMA_INIT(8'h00)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .div_tap   (div_tap),
      .bus       (tbus),
      .timer_irq (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      tbus.sel  = 1'b1;
      tbus.wr   = 1'b1;
      tbus.addr = a;
      tbus.din  = d;
      step();
      tbus.sel  = 1'b0;
      tbus.wr   = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      tbus.sel  = 1'b1;
      tbus.rd   = 1'b1;
      tbus.addr = a;
      #1;
      chk({tag, "_en"}, {7'd0, tbus.dout_en}, 8'h01);
      chk(tag, tbus.dout, exp);
      tbus.sel  = 1'b0;
      tbus.rd   = 1'b0;
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      chk(tag, {7'd0, timer_irq}, {7'd0, exp});
   endtask

   // One full high-then-low pulse on the 262144 Hz tap
   task automatic toggle_tap1();
      div_tap = 4'b0010;
      step();
      div_tap = 4'b0000;
      step();
   endtask

   initial begin
      n_pass    = 0;
      n_fail    = 0;
      n_total   = 0;
      nreset    = 1'b0;
      div_tap   = 4'b0000;
      tbus.sel  = 1'b0;
      tbus.wr   = 1'b0;
      tbus.rd   = 1'b0;
      tbus.addr = 2'd0;
      tbus.din  = 8'h00;

      // Reset state
      #12;
      chk_irq("rst_irq", 1'b0);
      chk("rst_idle_en", {7'd0, tbus.dout_en}, 8'h00);
      chk("rst_idle_dout", tbus.dout, 8'hFF);
      step();
      nreset = 1'b1;
      read_chk("rst_tima", 2'd1, 8'h00);
      read_chk("rst_tma", 2'd2, 8'h00);
      read_chk("rst_tac", 2'd3, 8'hF8);

      // TAC readback and addr 0 read
      cpu_write(2'd3, 8'h07);
      read_chk("tac_07", 2'd3, 8'hFF);
      tbus.sel = 1'b1; tbus.rd = 1'b1; tbus.addr = 2'd0;
      #1;
      chk("addr0_en", {7'd0, tbus.dout_en}, 8'h00);
      chk("addr0_dout", tbus.dout, 8'hFF);
      tbus.sel = 1'b0; tbus.rd = 1'b0;
      cpu_write(2'd3, 8'h00);

      // Basic overflow and reload with a single irq pulse
      cpu_write(2'd2, 8'h40);
      cpu_write(2'd1, 8'hFE);
      cpu_write(2'd3, 8'h05);
      toggle_tap1();
      read_chk("inc_ff", 2'd1, 8'hFF);
      chk_irq("run_irq", 1'b0);
      toggle_tap1();
      read_chk("ovf_tima", 2'd1, 8'h00);
      chk_irq("ovf_irq", 1'b0);
      step();
      read_chk("reload_tima", 2'd1, 8'h40);
      chk_irq("reload_irq", 1'b1);
      step();
      chk_irq("after_reload_irq", 1'b0);
      read_chk("after_reload_tima", 2'd1, 8'h40);

      // TIMA write during OVF cancels the reload
      cpu_write(2'd1, 8'hFF);
      toggle_tap1();
      read_chk("ovf2_tima", 2'd1, 8'h00);
      cpu_write(2'd1, 8'h12);
      read_chk("ovf_wr_tima", 2'd1, 8'h12);
      chk_irq("ovf_wr_irq", 1'b0);
      step();
      chk_irq("ovf_wr_irq_next", 1'b0);
      read_chk("ovf_wr_tima_next", 2'd1, 8'h12);

      // TMA write during RELOAD passes to TIMA, irq still pulses
      cpu_write(2'd1, 8'hFF);
      toggle_tap1();
      chk_irq("ovf3_irq", 1'b0);
      step();
      chk_irq("reload3_irq", 1'b1);
      cpu_write(2'd2, 8'h77);
      read_chk("reload_tma_tima", 2'd1, 8'h77);
      read_chk("reload_tma_tma", 2'd2, 8'h77);
      chk_irq("reload_tma_irq_end", 1'b0);

      // TIMA write during RELOAD is ignored
      cpu_write(2'd1, 8'hFF);
      toggle_tap1();
      step();
      cpu_write(2'd1, 8'h55);
      read_chk("reload_wr_ignored", 2'd1, 8'h77);

      // CPU write wins over a same-cycle increment
      div_tap = 4'b0010;
      step();
      div_tap = 4'b0000;
      cpu_write(2'd1, 8'h30);
      read_chk("wr_beats_inc", 2'd1, 8'h30);
      step();
      read_chk("wr_beats_inc_next", 2'd1, 8'h30);

      // Clearing TAC with the tap high produces exactly one increment
      div_tap = 4'b0001;
      cpu_write(2'd3, 8'h04);
      step();
      read_chk("glitch_pre", 2'd1, 8'h30);
      cpu_write(2'd3, 8'h00);
      step();
      read_chk("glitch_inc", 2'd1, 8'h31);
      step();
      read_chk("glitch_once", 2'd1, 8'h31);
      div_tap = 4'b0000;

      // Reset asserted during OVF aborts without an interrupt
      cpu_write(2'd3, 8'h05);
      cpu_write(2'd2, 8'h40);
      cpu_write(2'd1, 8'hFF);
      toggle_tap1();
      #2;
      nreset = 1'b0;
      #1;
      chk_irq("rst_ovf_irq", 1'b0);
      read_chk("rst_ovf_tima", 2'd1, 8'h00);
      read_chk("rst_ovf_tma", 2'd2, 8'h00);
      read_chk("rst_ovf_tac", 2'd3, 8'hF8);
      step();
      nreset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_irq("post_rst_irq", 1'b0);
         read_chk("post_rst_tima", 2'd1, 8'h00);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
